// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU for the EX stage: single-cycle logic/arith ops plus an
// iterative MUL/MULHU/DIVU/REMU unit enabled by defining ALU_MULDIV_EN.
module alu_multicycle #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CTRL_W-1:0] alu_control,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   alu_result,
    output logic              zero,
    output logic              illegal
);

    localparam logic [CTRL_W-1:0] OP_AND   = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] OP_OR    = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] OP_ADD   = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] OP_SUB   = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] OP_SLT   = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] OP_MUL   = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] OP_MULHU = CTRL_W'(4'b1001);
    localparam logic [CTRL_W-1:0] OP_DIVU  = CTRL_W'(4'b1010);
    localparam logic [CTRL_W-1:0] OP_REMU  = CTRL_W'(4'b1011);

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;
`else
    typedef enum logic {IDLE, FIN} state_t;
`endif

    state_t          state;
    logic [XLEN-1:0] res_next;
    logic            ill_next;

`ifdef ALU_MULDIV_EN
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0]  count;
    logic [CTRL_W-1:0] op_q;
    // hi/lo: accumulator/multiplier for multiply, remainder/quotient for divide
    logic [XLEN-1:0]   hi, lo, opnd;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic              is_muldiv, div_by_zero, last_step;

    assign is_muldiv   = (alu_control == OP_MUL) || (alu_control == OP_MULHU) ||
                         (alu_control == OP_DIVU) || (alu_control == OP_REMU);
    assign div_by_zero = ((alu_control == OP_DIVU) || (alu_control == OP_REMU)) && (b == '0);
    assign last_step   = (count == CNT_W'(XLEN - 1));
    assign mul_sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign div_trial   = {hi, lo[XLEN-1]} - {1'b0, opnd};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        step_hi = hi;
        step_lo = lo;
        if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo[XLEN-1:1]};
        end else if (!div_trial[XLEN]) begin
            step_hi = div_trial[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], 1'b1};
        end else begin
            step_hi = {hi[XLEN-2:0], lo[XLEN-1]};
            step_lo = {lo[XLEN-2:0], 1'b0};
        end
    end
`endif

    // Value captured into alu_result/zero/illegal at the FIN-entry edge.
    always_comb begin
        res_next = '0;
        ill_next = 1'b0;
        case (alu_control)
            OP_AND:   res_next = a & b;
            OP_OR:    res_next = a | b;
            OP_ADD:   res_next = a + b;
            OP_SUB:   res_next = a - b;
            OP_SLT:   res_next = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
`ifdef ALU_MULDIV_EN
            OP_MUL, OP_MULHU: res_next = '0;
            OP_DIVU:  res_next = '1;
            OP_REMU:  res_next = a;
`endif
            default:  ill_next = 1'b1;
        endcase
`ifdef ALU_MULDIV_EN
        if (state == ITER) begin
            ill_next = 1'b0;
            res_next = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? step_lo : step_hi;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            alu_result <= '0;
            zero       <= 1'b0;
            illegal    <= 1'b0;
`ifdef ALU_MULDIV_EN
            count      <= '0;
            op_q       <= '0;
            hi         <= '0;
            lo         <= '0;
            opnd       <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef ALU_MULDIV_EN
                        if (is_muldiv && !div_by_zero) begin
                            state <= ITER;
                            busy  <= 1'b1;
                            count <= '0;
                            op_q  <= alu_control;
                            hi    <= '0;
                            lo    <= a;
                            opnd  <= b;
                        end else
`endif
                        begin
                            state      <= FIN;
                            done       <= 1'b1;
                            alu_result <= res_next;
                            zero       <= (res_next == '0);
                            illegal    <= ill_next;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                ITER: begin
                    hi    <= step_hi;
                    lo    <= step_lo;
                    count <= count + 1'b1;
                    if (last_step) begin
                        state      <= FIN;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        alu_result <= res_next;
                        zero       <= (res_next == '0);
                        illegal    <= ill_next;
                    end
                end
`endif
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases plus random ops against a
// behavioural model; follows ALU_MULDIV_EN to decide whether mul/div codes are legal.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] a, b;
    logic        busy, done, zero, illegal;
    logic [31:0] alu_result;

    int errors = 0;
    int checks = 0;

    alu_multicycle #(.XLEN(32), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
        .a(a), .b(b), .busy(busy), .done(done), .alu_result(alu_result),
        .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: result, illegal flag and start-to-done latency in cycles.
    function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic ill, output int lat);
        longint unsigned p;
        p   = {32'b0, x} * {32'b0, y};
        r   = 32'h0;
        ill = 1'b0;
        lat = 1;
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
            4'b1000: begin r = p[31:0];  lat = 33; end
            4'b1001: begin r = p[63:32]; lat = 33; end
            4'b1010: begin r = (y == 0) ? 32'hFFFF_FFFF : x / y; lat = (y == 0) ? 1 : 33; end
            4'b1011: begin r = (y == 0) ? x : x % y;             lat = (y == 0) ? 1 : 33; end
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the IDLE
    // cycle after FIN, so consecutive calls run back-to-back.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] opa,
                          input logic [31:0] opb, input bit noise);
        logic [31:0] er;
        logic        ei;
        int          lat;
        int          cycles = 0;
        int          busy_cycles = 0;
        bit          seen = 0;
        model(op, opa, opb, er, ei, lat);
        start = 1'b1; alu_control = op; a = opa; b = opb;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            cycles++;
            if (done) seen = 1;
            else begin
                if (busy) busy_cycles++;
                if (noise) begin
                    start = 1'($urandom); a = $urandom; b = $urandom; alu_control = 4'($urandom);
                end
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(cycles), 64'(lat));
        check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(lat - 1));
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " result"}, 64'(alu_result), 64'(er));
        check({tag, " zero"}, 64'(zero), 64'(er == 32'h0));
        check({tag, " illegal"}, 64'(illegal), 64'(ei));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
        check({tag, " result_held"}, 64'(alu_result), 64'(er));
    endtask

    initial begin
        bit done_in_reset;
        rst_n = 1'b0; start = 1'b0; alu_control = 4'h0; a = 32'h0; b = 32'h0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(alu_result), 64'd0);
        check("reset zero", 64'(zero), 64'd0);
        check("reset illegal", 64'(illegal), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sub_neg", 4'b0110, 32'd5, 32'd7, 0);
        run_op("slt_m1_1", 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("slt_1_m1", 4'b0111, 32'd1, 32'hFFFF_FFFF, 0);
        run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        run_op("or", 4'b0001, 32'hF000_0001, 32'h0000_1000, 0);
        run_op("mul_big", 4'b1000, 32'h0001_0000, 32'h0001_0000, 0);
        run_op("mulhu_big", 4'b1001, 32'h0001_0000, 32'h0001_0000, 0);
        run_op("divu_noise", 4'b1010, 32'd100, 32'd7, 1);
        run_op("remu", 4'b1011, 32'd100, 32'd7, 0);
        run_op("divu_by0", 4'b1010, 32'd9, 32'd0, 0);
        run_op("remu_by0", 4'b1011, 32'd9, 32'd0, 0);
        run_op("illegal_0101", 4'b0101, 32'd3, 32'd4, 0);
        run_op("code_1000", 4'b1000, 32'd6, 32'd7, 0);
        run_op("illegal_0101b", 4'b0101, 32'd8, 32'd9, 0);

`ifdef ALU_MULDIV_EN
        // Abort a divide mid-iteration; previous op left zero=1, illegal=1.
        start = 1'b1; alu_control = 4'b1010; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("midop busy", 64'(busy), 64'd1);
        check("midop done", 64'(done), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort result", 64'(alu_result), 64'd0);
        check("abort zero", 64'(zero), 64'd0);
        check("abort illegal", 64'(illegal), 64'd0);
        done_in_reset = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_in_reset = 1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_in_reset = 1;
        end
        check("abort no_done", 64'(done_in_reset), 64'd0);
`endif
        run_op("add_3_4", 4'b0010, 32'd3, 32'd4, 0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] x, y;
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op($sformatf("rand%0d_op%0h", i, op), op, x, y, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
